// File: rtl/instr_mem_fetch_if.sv
// Fetch/load bus for instr_mem_fetch: program-load port, fetch request and
// registered fetch response. slave = memory side, master = fetch/loader side.
interface instr_mem_fetch_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 1024
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   load_start;
  logic                   load_valid;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   load_done;
  logic                   loading;
  logic [CW-1:0]          load_count;
  logic                   load_overflow;
  logic                   req_valid;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   req_ready;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [INSTR_WIDTH-1:0] resp_instr;
  logic [1:0]             resp_fault;

  modport slave (
    input  load_start, load_valid, load_data, load_done,
    input  req_valid, req_addr, resp_ready,
    output loading, load_count, load_overflow,
    output req_ready, resp_valid, resp_instr, resp_fault
  );

  modport master (
    output load_start, load_valid, load_data, load_done,
    output req_valid, req_addr, resp_ready,
    input  loading, load_count, load_overflow,
    input  req_ready, resp_valid, resp_instr, resp_fault
  );
endinterface

// File: rtl/instr_mem_fetch.sv
// Instruction memory with sequential program load and a one-cycle registered fetch.
// Faulted fetches (misaligned / out of range) return NOP_INSTR; fetch is blocked while loading.
module instr_mem_fetch #(
  parameter int                     ADDR_WIDTH  = 64,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     DEPTH       = 1024,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_mem_fetch_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic [0:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [CW-1:0]          wr_base;
  logic                   wr_en;
  logic                   resp_valid_q;
  logic [INSTR_WIDTH-1:0] resp_instr_q;
  logic [1:0]             resp_fault_q;
  logic [1:0]             fault;
  logic [IW-1:0]          idx;
  logic                   req_ready;
  logic                   accept;

  // A load_start cycle counts as a load cycle, so a word offered with it lands at index 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_base = bus.load_start ? '0 : cnt_q;
    if (bus.load_start) begin
      state_d = S_LOAD;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
    if ((state_q == S_LOAD || bus.load_start) && bus.load_valid) begin
      if (wr_base < DEPTH_C) begin
        wr_en = 1'b1;
        cnt_d = wr_base + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (state_q == S_LOAD && !bus.load_start && bus.load_done) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_base[IW-1:0]] <= bus.load_data;
    end
  end

  assign idx = bus.req_addr[IW+1:2];

  // Misalignment outranks range so a bad low-bit address always reports 01.
  always_comb begin
    if (|bus.req_addr[1:0]) begin
      fault = 2'b01;
    end else if (|bus.req_addr[ADDR_WIDTH-1:IW+2]) begin
      fault = 2'b10;
    end else begin
      fault = 2'b00;
    end
  end

  assign req_ready = (state_q == S_IDLE) && !bus.load_start && (!resp_valid_q || bus.resp_ready);
  assign accept    = bus.req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_instr_q <= '0;
      resp_fault_q <= 2'b00;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      resp_fault_q <= fault;
      resp_instr_q <= (fault == 2'b00) ? mem[idx] : NOP_INSTR;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.loading       = (state_q == S_LOAD);
  assign bus.load_count    = cnt_q;
  assign bus.load_overflow = ovf_q;
  assign bus.req_ready     = req_ready;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_instr    = resp_instr_q;
  assign bus.resp_fault    = resp_fault_q;
endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: a full-size instance for load/fetch/stall/reset
// and a DEPTH=4 instance for load overflow.
module tb_instr_mem_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_fetch_if #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .DEPTH(1024)) bus ();
  instr_mem_fetch_if #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .DEPTH(4))    bus4 ();

  instr_mem_fetch #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .DEPTH(1024), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  instr_mem_fetch #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .DEPTH(4), .NOP_INSTR(32'h0000_0013)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  fault;
    logic [31:0] instr;
  } fvec_t;

  int errors = 0;
  int checks = 0;
  logic [31:0] aw [5];
  logic [31:0] bw [6];
  fvec_t vec [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 5; i++) aw[i] = 32'hA0A0_0000 | 32'(i);
    for (int i = 0; i < 6; i++) bw[i] = 32'hB0B0_0000 | 32'(i);
    vec[0] = '{64'h0, 2'b00, aw[0]};
    vec[1] = '{64'h4, 2'b00, aw[1]};
    vec[2] = '{64'h8, 2'b00, aw[2]};
    vec[3] = '{64'hC, 2'b00, aw[3]};
    vec[4] = '{64'h10, 2'b00, aw[4]};
    vec[5] = '{64'h6, 2'b01, NOP};
    vec[6] = '{64'h1000, 2'b10, NOP};
    vec[7] = '{64'hFFFF_FFFF_FFFF_FFFC, 2'b10, NOP};
    vec[8] = '{64'h1001, 2'b01, NOP};

    bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0; bus.load_done = 0;
    bus.req_valid = 0; bus.req_addr = '0; bus.resp_ready = 1;
    bus4.load_start = 0; bus4.load_valid = 0; bus4.load_data = '0; bus4.load_done = 0;
    bus4.req_valid = 0; bus4.req_addr = '0; bus4.resp_ready = 1;

    // Reset state
    #12;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_instr", 64'(bus.resp_instr), 64'd0);
    chk("rst_resp_fault", 64'(bus.resp_fault), 64'd0);
    chk("rst_loading", 64'(bus.loading), 64'd0);
    chk("rst_load_count", 64'(bus.load_count), 64'd0);
    chk("rst_overflow", 64'(bus.load_overflow), 64'd0);
    rst_n = 1;
    tick();

    // Load five words while a fetch request is pending
    bus.req_valid = 1; bus.req_addr = 64'h0;
    bus.load_start = 1;
    #1 chk("gate_start_req_ready", 64'(bus.req_ready), 64'd0);
    tick();
    bus.load_start = 0;
    chk("load_loading", 64'(bus.loading), 64'd1);
    chk("load_count_0", 64'(bus.load_count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      bus.load_valid = 1; bus.load_data = aw[i]; bus.load_done = (i == 4);
      #1 chk("gate_load_req_ready", 64'(bus.req_ready), 64'd0);
      tick();
      chk("load_count", 64'(bus.load_count), 64'(i + 1));
    end
    bus.load_valid = 0; bus.load_done = 0;
    chk("load_exit_loading", 64'(bus.loading), 64'd0);
    chk("load_no_resp", 64'(bus.resp_valid), 64'd0);
    chk("load_exit_req_ready", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 0;
    tick();

    // Back-to-back fetch table
    bus.resp_ready = 1;
    for (int i = 0; i < 9; i++) begin
      bus.req_valid = 1; bus.req_addr = vec[i].addr;
      #1 chk("fetch_req_ready", 64'(bus.req_ready), 64'd1);
      tick();
      chk("fetch_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("fetch_resp_instr", 64'(bus.resp_instr), 64'(vec[i].instr));
      chk("fetch_resp_fault", 64'(bus.resp_fault), 64'(vec[i].fault));
    end
    bus.req_valid = 0;
    tick();
    chk("drain_resp_valid", 64'(bus.resp_valid), 64'd0);

    // Backpressure: A0 held for 3 cycles, then queued addr 4 accepted
    bus.resp_ready = 0; bus.req_valid = 1; bus.req_addr = 64'h0;
    tick();
    chk("bp_first_valid", 64'(bus.resp_valid), 64'd1);
    bus.req_addr = 64'h4;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      tick();
      chk("bp_hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("bp_hold_instr", 64'(bus.resp_instr), 64'(aw[0]));
    end
    bus.resp_ready = 1;
    #1 chk("bp_release_req_ready", 64'(bus.req_ready), 64'd1);
    tick();
    chk("bp_next_instr", 64'(bus.resp_instr), 64'(aw[1]));
    chk("bp_next_valid", 64'(bus.resp_valid), 64'd1);
    bus.req_valid = 0;
    tick();
    chk("bp_drain", 64'(bus.resp_valid), 64'd0);

    // Pending response survives a load start
    bus.resp_ready = 0; bus.req_valid = 1; bus.req_addr = 64'h8;
    tick();
    bus.req_valid = 0; bus.load_start = 1;
    tick();
    bus.load_start = 0; bus.load_done = 1;
    tick();
    bus.load_done = 0;
    chk("pend_valid", 64'(bus.resp_valid), 64'd1);
    chk("pend_instr", 64'(bus.resp_instr), 64'(aw[2]));
    chk("pend_count_cleared", 64'(bus.load_count), 64'd0);
    bus.resp_ready = 1;
    tick();
    chk("pend_drain", 64'(bus.resp_valid), 64'd0);

    // Overflow on the DEPTH=4 instance
    bus4.load_start = 1;
    tick();
    bus4.load_start = 0;
    for (int i = 0; i < 6; i++) begin
      bus4.load_valid = 1; bus4.load_data = bw[i];
      tick();
      chk("ovf_count", 64'(bus4.load_count), 64'((i < 4) ? i + 1 : 4));
      chk("ovf_flag", 64'(bus4.load_overflow), 64'((i >= 4) ? 1 : 0));
    end
    bus4.load_valid = 0; bus4.load_done = 1;
    tick();
    bus4.load_done = 0;
    for (int i = 0; i < 4; i++) begin
      bus4.req_valid = 1; bus4.req_addr = 64'(i * 4);
      tick();
      chk("ovf_mem", 64'(bus4.resp_instr), 64'(bw[i]));
    end
    bus4.req_addr = 64'h10;
    tick();
    chk("ovf_range_fault", 64'(bus4.resp_fault), 64'd2);
    chk("ovf_range_instr", 64'(bus4.resp_instr), 64'(NOP));
    bus4.req_valid = 0;
    bus4.load_start = 1;
    tick();
    chk("ovf_cleared", 64'(bus4.load_overflow), 64'd0);
    chk("ovf_restart_count", 64'(bus4.load_count), 64'd0);
    bus4.load_valid = 1; bus4.load_data = 32'hC0C0_0000;
    tick();
    bus4.load_start = 0; bus4.load_valid = 0;
    chk("restart_with_data_count", 64'(bus4.load_count), 64'd1);
    bus4.load_done = 1;
    tick();
    bus4.load_done = 0;
    bus4.req_valid = 1; bus4.req_addr = 64'h0;
    tick();
    bus4.req_valid = 0;
    chk("restart_word0", 64'(bus4.resp_instr), 64'h0000_0000_C0C0_0000);

    // Async reset mid-stall
    bus.resp_ready = 0; bus.req_valid = 1; bus.req_addr = 64'h4;
    tick();
    bus.req_valid = 0;
    chk("stall_before_rst", 64'(bus.resp_instr), 64'(aw[1]));
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", 64'(bus.resp_valid), 64'd0);
    chk("async_rst_instr", 64'(bus.resp_instr), 64'd0);
    #2 rst_n = 1;
    tick();
    bus.resp_ready = 1; bus.req_valid = 1; bus.req_addr = 64'h0;
    tick();
    bus.req_valid = 0;
    chk("post_rst_mem", 64'(bus.resp_instr), 64'(aw[0]));
    chk("post_rst_fault", 64'(bus.resp_fault), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
